// File: rtl/timer.sv
// Saturating WIDTH-bit down-counter with reload on start and synchronous active-low reset.
// Optional registered expiry pulse on the 1->0 tick, enabled by TIMER_EXPIRE_PULSE_EN.
module timer #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned LOAD  = (2 ** WIDTH) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             timer_start,
    input  logic             timer_tick,
`ifdef TIMER_EXPIRE_PULSE_EN
    output logic             timer_expire,
`endif
    output logic             timer_up,
    output logic [WIDTH-1:0] timer_count
);

    localparam logic [WIDTH-1:0] LoadVal = LOAD[WIDTH-1:0];
    localparam logic [WIDTH-1:0] One     = {{(WIDTH - 1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             w_zero;
    logic             w_dec;

    assign w_zero = (r_count == '0);
    // Ticks at zero are swallowed so the counter saturates instead of wrapping.
    assign w_dec  = timer_tick && !w_zero;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= LoadVal;
        end else if (timer_start) begin
            r_count <= LoadVal;
        end else if (w_dec) begin
            r_count <= r_count - One;
        end
    end

    assign timer_up    = w_zero;
    assign timer_count = r_count;

`ifdef TIMER_EXPIRE_PULSE_EN
    logic r_expire;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_expire <= 1'b0;
        end else begin
            r_expire <= !timer_start && timer_tick && (r_count == One);
        end
    end

    assign timer_expire = r_expire;
`endif

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: directed scenarios plus randomized traffic against a
// behavioural counter model.
module tb_timer;

    localparam int unsigned WIDTH = 7;
    localparam int          LOAD  = 127;

    logic             clk;
    logic             reset;
    logic             timer_start;
    logic             timer_tick;
    logic             timer_up;
    logic [WIDTH-1:0] timer_count;
`ifdef TIMER_EXPIRE_PULSE_EN
    logic             timer_expire;
`endif

    int n_checks;
    int n_errors;

    // Reference model state
    int m_count;
    bit m_expire;

    timer #(
        .WIDTH(WIDTH),
        .LOAD (LOAD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .timer_start (timer_start),
        .timer_tick  (timer_tick),
`ifdef TIMER_EXPIRE_PULSE_EN
        .timer_expire(timer_expire),
`endif
        .timer_up    (timer_up),
        .timer_count (timer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, wait past the edge, then advance the model.
    task automatic step(input logic s, input logic t, input logic r);
        int prev;
        reset       = r;
        timer_start = s;
        timer_tick  = t;
        @(posedge clk);
        #1;
        prev     = m_count;
        m_expire = 1'b0;
        if (!r) begin
            m_count = LOAD;
        end else if (s) begin
            m_count = LOAD;
        end else if (t && m_count > 0) begin
            m_count = m_count - 1;
            m_expire = (prev == 1);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (timer_count !== 7'(LOAD) || timer_up !== 1'b0) begin
            $display("FAIL reset_hold: count=%0d up=%b, want count=%0d up=0",
                     timer_count, timer_up, LOAD);
            n_errors++;
        end
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (timer_count !== 7'(LOAD) || timer_up !== 1'b0) begin
            $display("FAIL reset_release: count=%0d up=%b, want count=%0d up=0",
                     timer_count, timer_up, LOAD);
            n_errors++;
        end
`ifdef TIMER_EXPIRE_PULSE_EN
        n_checks++;
        if (timer_expire !== 1'b0) begin
            $display("FAIL reset_expire: expire=%b, want 0", timer_expire);
            n_errors++;
        end
`endif
    endtask

    task automatic test_countdown();
        int pulses;
        pulses = 0;
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < LOAD - 1; i++) begin
            step(1'b0, 1'b1, 1'b1);
`ifdef TIMER_EXPIRE_PULSE_EN
            if (timer_expire === 1'b1) pulses++;
`endif
        end
        n_checks++;
        if (timer_count !== 7'd1 || timer_up !== 1'b0) begin
            $display("FAIL countdown_at1: count=%0d up=%b, want count=1 up=0",
                     timer_count, timer_up);
            n_errors++;
        end
        step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (timer_count !== 7'd0 || timer_up !== 1'b1) begin
            $display("FAIL countdown_at0: count=%0d up=%b, want count=0 up=1",
                     timer_count, timer_up);
            n_errors++;
        end
`ifdef TIMER_EXPIRE_PULSE_EN
        n_checks++;
        if (timer_expire !== 1'b1 || pulses != 0) begin
            $display("FAIL expire_pulse: expire=%b early_pulses=%0d, want expire=1 early=0",
                     timer_expire, pulses);
            n_errors++;
        end
`endif
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1);
            n_checks++;
            if (timer_count !== 7'd0 || timer_up !== 1'b1) begin
                $display("FAIL saturate[%0d]: count=%0d up=%b, want count=0 up=1",
                         i, timer_count, timer_up);
                n_errors++;
            end
`ifdef TIMER_EXPIRE_PULSE_EN
            n_checks++;
            if (timer_expire !== 1'b0) begin
                $display("FAIL saturate_expire[%0d]: expire=%b, want 0", i, timer_expire);
                n_errors++;
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (timer_count !== 7'd77) begin
            $display("FAIL mid_count: count=%0d, want 77", timer_count);
            n_errors++;
        end
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (timer_count !== 7'(LOAD) || timer_up !== 1'b0) begin
            $display("FAIL mid_reset: count=%0d up=%b, want count=%0d up=0",
                     timer_count, timer_up, LOAD);
            n_errors++;
        end
    endtask

    task automatic test_restart();
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (timer_count !== 7'(LOAD)) begin
            $display("FAIL restart_load: count=%0d, want %0d", timer_count, LOAD);
            n_errors++;
        end
        for (int i = 0; i < LOAD - 1; i++) step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (timer_up !== 1'b0) begin
            $display("FAIL restart_early_up: up=%b, want 0", timer_up);
            n_errors++;
        end
        step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (timer_up !== 1'b1) begin
            $display("FAIL restart_up: up=%b, want 1", timer_up);
            n_errors++;
        end
        // Start at zero must drop timer_up on the very next cycle.
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (timer_up !== 1'b0 || timer_count !== 7'(LOAD)) begin
            $display("FAIL restart_from0: count=%0d up=%b, want count=%0d up=0",
                     timer_count, timer_up, LOAD);
            n_errors++;
        end
    endtask

    task automatic test_priority();
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < LOAD - 5; i++) step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (timer_count !== 7'd5) begin
            $display("FAIL prio_setup: count=%0d, want 5", timer_count);
            n_errors++;
        end
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (timer_count !== 7'(LOAD)) begin
            $display("FAIL prio_start_tick: count=%0d, want %0d", timer_count, LOAD);
            n_errors++;
        end
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (timer_count !== 7'(LOAD)) begin
            $display("FAIL prio_reset_tick: count=%0d, want %0d", timer_count, LOAD);
            n_errors++;
        end
        step(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (timer_count !== 7'(LOAD) || timer_up !== 1'b0) begin
            $display("FAIL prio_reset_start: count=%0d up=%b, want count=%0d up=0",
                     timer_count, timer_up, LOAD);
            n_errors++;
        end
    endtask

    task automatic test_random();
        int start_rate;
        logic s, t, r;
        for (int i = 0; i < 4000; i++) begin
            // Alternate between restart-heavy and long-countdown phases.
            start_rate = ((i / 500) % 2 == 0) ? 12 : 400;
            s = ($urandom_range(start_rate - 1, 0) == 0);
            t = ($urandom_range(2, 0) != 0);
            r = ($urandom_range(599, 0) != 0);
            step(s, t, r);
            n_checks++;
            if (timer_count !== 7'(m_count) || timer_up !== (m_count == 0)) begin
                $display("FAIL random[%0d]: count=%0d up=%b, want count=%0d up=%b",
                         i, timer_count, timer_up, m_count, (m_count == 0));
                n_errors++;
            end
`ifdef TIMER_EXPIRE_PULSE_EN
            n_checks++;
            if (timer_expire !== m_expire) begin
                $display("FAIL random_expire[%0d]: expire=%b, want %b",
                         i, timer_expire, m_expire);
                n_errors++;
            end
`endif
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        m_count     = LOAD;
        m_expire    = 1'b0;
        reset       = 1'b0;
        timer_start = 1'b0;
        timer_tick  = 1'b0;
        test_reset();
        test_countdown();
        test_reset_mid();
        test_restart();
        test_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 Parameter WIDTH, default 7, counter width in bits (legal range 2..16).
REQ-002 Parameter LOAD, default 2**WIDTH-1 (127), value loaded by start and by reset (legal range 1..2**WIDTH-1).
REQ-003 The clock and reset SHALL be: one clock; reset is synchronous and active-low (ports clk and reset).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-low reset; asserted when 0, sampled on rising clk.
REQ-006 timer_start  input  1  level-sampled; high in a cycle reloads the counter.
REQ-007 timer_tick  input  1  level-sampled decrement enable; each cycle high counts one tick.
REQ-008 timer_up  output  1  high while the counter equals 0.
REQ-009 timer_count  output  WIDTH  current counter value.

Function
REQ-010 The timer SHALL hold one WIDTH-bit down-counter register; all state updates occur on rising clk only.
REQ-011 Priority per cycle SHALL be: reset (0) > timer_start (1) > timer_tick (1) > hold.
REQ-012 timer_start high SHALL load LOAD on that edge, regardless of timer_tick or current value.
REQ-013 timer_tick high with start low and counter nonzero SHALL decrement the counter by exactly 1 on that edge.
REQ-014 timer_tick high with counter 0 SHALL leave the counter at 0 (saturate, no wrap to all-ones).
REQ-015 No tick and no start SHALL hold the counter.
REQ-016 timer_up SHALL be combinational from the register (counter == 0), valid in the cycle after the edge that writes 0, with no extra latency.
REQ-017 timer_up SHALL stay high until a start or reset reloads the counter.
REQ-018 A start during an active countdown SHALL restart from LOAD; timer_up falls the cycle after that start edge.
REQ-019 timer_count SHALL equal the counter register directly.
REQ-020 From LOAD, exactly LOAD tick cycles SHALL be needed to assert timer_up; non-tick cycles interleaved in between SHALL not change the count.

Reset
REQ-021 When reset is 0 on a rising clk, the counter SHALL load LOAD, so timer_up = 0 and timer_count = LOAD on the following cycle.
REQ-022 Reset SHALL override simultaneous timer_start and timer_tick.
REQ-023 Reset asserted mid-countdown SHALL abandon the count; no partial state SHALL survive.
REQ-024 There SHALL be no asynchronous reset path.

Configuration
REQ-025 Macro TIMER_EXPIRE_PULSE_EN defined: output timer_expire (1 bit) SHALL be a registered one-cycle pulse, high in the cycle after the edge where the counter goes from 1 to 0 by a tick.
REQ-026 With TIMER_EXPIRE_PULSE_EN defined, timer_expire SHALL reset to 0, SHALL NOT pulse on saturated ticks at 0, and SHALL NOT pulse when start or reset wins that cycle.
REQ-027 Macro TIMER_EXPIRE_PULSE_EN undefined: port timer_expire and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-028 Reset 0 for 10 cycles, then release -> timer_count = 127, timer_up = 0.
REQ-029 Start pulse, then 126 single-cycle ticks -> timer_count = 1, timer_up = 0; 127th tick -> timer_count = 0, timer_up = 1; 3 more ticks -> timer_count stays 0, timer_up stays 1.
REQ-030 Start, 50 ticks (timer_count = 77), then reset 0 for one cycle -> timer_count = 127, timer_up = 0.
REQ-031 Start, 50 ticks, start again -> timer_count = 127; then 127 ticks -> timer_up = 1 exactly after the 127th tick.
REQ-032 timer_start and timer_tick high in the same cycle at timer_count = 5 -> timer_count = 127; reset 0 with start = 1 -> timer_count = 127.
REQ-033 With TIMER_EXPIRE_PULSE_EN: countdown from 127 -> timer_expire high for exactly 1 cycle after the 127th tick, low during later saturated ticks; build without the macro compiles with no timer_expire port.
